// File: rtl/sdram_burst_arbiter.sv
// Round-robin scheduler of camera-write / VGA-read SDRAM bursts: generates frame-wrapping
// burst addresses and flips ping-pong banks so the display reads only completed frames.
module sdram_burst_arbiter #(
  parameter int unsigned WR_LEN     = 512,
  parameter int unsigned RD_LEN     = 512,
  parameter int unsigned FRAME_SIZE = 307200,
  parameter int unsigned ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [9:0]        wr_fifo_cnt,
  input  logic [9:0]        rd_fifo_cnt,
  input  logic              rd_valid,
  input  logic              pingpang_en,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              cmd_wr_req,
  output logic              cmd_rd_req,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [9:0]        cmd_len,
  input  logic              cmd_ack,
  input  logic              burst_done,
  output logic              wr_bank,
  output logic              rd_bank
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned PTR_W   = ADDR_W - 2;
  localparam int unsigned RD_ROOM = 1023 - RD_LEN;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BUSY,
    RD_REQ,
    RD_BUSY
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             last_wr;
  logic             stale;

  logic             wr_ok;
  logic             rd_ok;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             wr_wrap;
  logic             rd_wrap;

  // Port eligibility and next-burst pointers
  assign wr_ok      = init_done & (wr_fifo_cnt >= CNT_W'(WR_LEN));
  assign rd_ok      = init_done & rd_valid & (rd_fifo_cnt <= CNT_W'(RD_ROOM));
  assign wr_ptr_inc = wr_ptr + PTR_W'(WR_LEN);
  assign rd_ptr_inc = rd_ptr + PTR_W'(RD_LEN);
  assign wr_wrap    = (wr_ptr_inc == PTR_W'(FRAME_SIZE));
  assign rd_wrap    = (rd_ptr_inc == PTR_W'(FRAME_SIZE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_wr_req <= 1'b0;
      cmd_rd_req <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_wr    <= 1'b0;
      stale      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A load in the grant cycle already counts as a cleared pointer/bank
          if (wr_ok && (!rd_ok || !last_wr)) begin
            state      <= WR_REQ;
            cmd_wr_req <= 1'b1;
            cmd_addr   <= wr_load ? '0 : {1'b0, wr_bank, wr_ptr};
            cmd_len    <= CNT_W'(WR_LEN);
            last_wr    <= 1'b1;
          end else if (rd_ok) begin
            state      <= RD_REQ;
            cmd_rd_req <= 1'b1;
            cmd_addr   <= rd_load ? '0 : {1'b0, rd_bank, rd_ptr};
            cmd_len    <= CNT_W'(RD_LEN);
            last_wr    <= 1'b0;
          end
        end

        WR_REQ: begin
          if (cmd_ack) begin
            state      <= WR_BUSY;
            cmd_wr_req <= 1'b0;
            stale      <= wr_load;
          end else if (wr_load) begin
            state      <= IDLE;
            cmd_wr_req <= 1'b0;
          end
        end

        RD_REQ: begin
          if (cmd_ack) begin
            state      <= RD_BUSY;
            cmd_rd_req <= 1'b0;
            stale      <= rd_load;
          end else if (rd_load) begin
            state      <= IDLE;
            cmd_rd_req <= 1'b0;
          end
        end

        WR_BUSY: begin
          // stale marks a burst overtaken by a load: it finishes but must not move the pointer
          if (burst_done) begin
            state <= IDLE;
            stale <= 1'b0;
            if (!stale && !wr_load) begin
              wr_ptr <= wr_wrap ? '0 : wr_ptr_inc;
              if (wr_wrap && pingpang_en) begin
                wr_bank <= ~wr_bank;
              end
            end
          end else if (wr_load) begin
            stale <= 1'b1;
          end
        end

        RD_BUSY: begin
          if (burst_done) begin
            state <= IDLE;
            stale <= 1'b0;
            if (!stale && !rd_load) begin
              rd_ptr <= rd_wrap ? '0 : rd_ptr_inc;
              if (rd_wrap) begin
                rd_bank <= pingpang_en ? ~wr_bank : 1'b0;
              end
            end
          end else if (rd_load) begin
            stale <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          cmd_wr_req <= 1'b0;
          cmd_rd_req <= 1'b0;
        end
      endcase

      // Loads and single-bank mode override any burst-completion update
      if (wr_load) begin
        wr_ptr  <= '0;
        wr_bank <= 1'b0;
      end
      if (rd_load) begin
        rd_ptr  <= '0;
        rd_bank <= 1'b0;
      end
      if (!pingpang_en) begin
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
      end
    end
  end

endmodule
